// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the Fetch -> Decode instruction buffer.
//   fetch_entry_t : one buffered instruction, {pc, instr}
//   FETCH_WIDTH   : instructions moved per cycle on either side of the buffer
//   FQ_DEPTH      : default number of buffer entries
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int FETCH_WIDTH = 2;
    localparam int FQ_DEPTH    = 8;

endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram
// DEPTH x fetch_entry_t register file backing the fetch queue.
// Two write ports (push slots 0 and 1) and two asynchronous read ports
// (output slots 0 and 1). Storage is deliberately not reset.
// Ports:
//   clk            : clock, writes on rising edge
//   we0/we1        : write enables for push slot 0 / slot 1
//   waddr0/waddr1  : write addresses (tail and tail+1)
//   wdata0/wdata1  : entries to write
//   raddr0/raddr1  : read addresses (head and head+1)
//   rdata0/rdata1  : combinational read data
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  fetch_entry_t  wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  fetch_entry_t  wdata1,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output fetch_entry_t  rdata0,
    output fetch_entry_t  rdata1
);

    fetch_entry_t mem [DEPTH];

    // The two write addresses are always tail and tail+1, so they never collide.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction buffer between Fetch and Decode. Fetch pushes up to two
// sequential instructions per cycle, Decode pops up to two in program order.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   Flush                : synchronous clear on branch/jump redirect
//   in_pc                : PC of push slot 0 (slot 1 uses in_pc + 4)
//   in_instr0/in_instr1  : instruction words for push slots 0 / 1
//   in_count             : push count 0..2 (3 treated as 0)
//   deq_count            : entries Decode takes this cycle (clamped to out_count)
//   Full                 : fewer than two free entries; Fetch stall
//   out_count            : valid output slots, min(count, 2)
//   out_pc0/out_instr0   : oldest entry (zero when not valid)
//   out_pc1/out_instr1   : second-oldest entry (zero when not valid)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Flush,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    input  logic [1:0]  in_count,
    input  logic [1:0]  deq_count,
    output logic        Full,
    output logic [1:0]  out_count,
    output logic [31:0] out_pc0,
    output logic [31:0] out_instr0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_instr1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head_plus1;
    logic [PTR_W-1:0] tail_plus1;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic             we0;
    logic             we1;
    fetch_entry_t     wdata0;
    fetch_entry_t     wdata1;
    fetch_entry_t     rdata0;
    fetch_entry_t     rdata1;

    assign head_plus1 = head + PTR_W'(1);
    assign tail_plus1 = tail + PTR_W'(1);

    // Status depends only on the registered count, never on this cycle's inputs.
    assign Full      = (count >= CNT_W'(DEPTH - 1));
    assign out_count = (count >= CNT_W'(FETCH_WIDTH)) ? 2'(FETCH_WIDTH) : count[1:0];

    // Push is all-or-nothing: refused entirely while Full, and in_count=3 means none.
    always_comb begin
        push_n = 2'd0;
        if (!Full) begin
            case (in_count)
                2'd1:    push_n = 2'd1;
                2'd2:    push_n = 2'd2;
                default: push_n = 2'd0;
            endcase
        end
    end

    // Decode may ask for more than is valid; it only gets what out_count shows.
    assign pop_n = (deq_count > out_count) ? out_count : deq_count;

    // Writes are suppressed under reset/Flush so an abandoned push leaves no trace.
    assign we0    = (push_n != 2'd0) && !reset && !Flush;
    assign we1    = (push_n == 2'd2) && !reset && !Flush;
    assign wdata0 = '{pc: in_pc,         instr: in_instr0};
    assign wdata1 = '{pc: in_pc + 32'd4, instr: in_instr1};

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_plus1),
        .wdata1 (wdata1),
        .raddr0 (head),
        .raddr1 (head_plus1),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    // Pointers wrap by natural overflow of their PTR_W-bit width.
    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count - CNT_W'(pop_n) + CNT_W'(push_n);
        end
    end

    // Slots not covered by out_count read as zero rather than stale storage.
    assign out_pc0    = (out_count != 2'd0) ? rdata0.pc    : 32'd0;
    assign out_instr0 = (out_count != 2'd0) ? rdata0.instr : 32'd0;
    assign out_pc1    = (out_count == 2'd2) ? rdata1.pc    : 32'd0;
    assign out_instr1 = (out_count == 2'd2) ? rdata1.instr : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run, all checked against a
// queue-based reference model of the buffer.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } model_entry_t;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  inc;
        logic [1:0]  deq;
        logic [1:0]  eoc;
        logic        efull;
        logic [31:0] epc0;
        logic [31:0] ei0;
        logic [31:0] epc1;
        logic [31:0] ei1;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        Flush;
    logic [31:0] in_pc;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic [1:0]  in_count;
    logic [1:0]  deq_count;
    logic        Full;
    logic [1:0]  out_count;
    logic [31:0] out_pc0;
    logic [31:0] out_instr0;
    logic [31:0] out_pc1;
    logic [31:0] out_instr1;

    int assertions = 0;
    int failures   = 0;

    model_entry_t model_q[$];
    vec_t         vecs[15];

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Flush      (Flush),
        .in_pc      (in_pc),
        .in_instr0  (in_instr0),
        .in_instr1  (in_instr1),
        .in_count   (in_count),
        .deq_count  (deq_count),
        .Full       (Full),
        .out_count  (out_count),
        .out_pc0    (out_pc0),
        .out_instr0 (out_instr0),
        .out_pc1    (out_pc1),
        .out_instr1 (out_instr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of {pc, instr}. Full is judged on the
    // occupancy before this cycle's pop; pops are limited to what is visible.
    task automatic modelStep(input logic rst, input logic fl, input logic [31:0] pc,
                             input logic [31:0] i0, input logic [31:0] i1,
                             input logic [1:0] inc, input logic [1:0] deq);
        int occ;
        int avail;
        int take;
        bit is_full;
        model_entry_t e;
        if (rst || fl) begin
            model_q.delete();
            return;
        end
        occ     = model_q.size();
        is_full = (DEPTH - occ) < 2;
        avail   = (occ < 2) ? occ : 2;
        take    = (int'(deq) < avail) ? int'(deq) : avail;
        for (int k = 0; k < take; k++) void'(model_q.pop_front());
        if (!is_full && (inc == 2'd1 || inc == 2'd2)) begin
            e.pc = pc; e.instr = i0;
            model_q.push_back(e);
            if (inc == 2'd2) begin
                e.pc = pc + 32'd4; e.instr = i1;
                model_q.push_back(e);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model and the DUT across one edge,
    // then leave time 1 ns past the edge for sampling.
    task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] pc,
                                 input logic [31:0] i0, input logic [31:0] i1,
                                 input logic [1:0] inc, input logic [1:0] deq);
        reset = rst; Flush = fl; in_pc = pc; in_instr0 = i0; in_instr1 = i1;
        in_count = inc; deq_count = deq;
        modelStep(rst, fl, pc, i0, i1, inc, deq);
        @(posedge clk);
        #1;
    endtask

    task automatic compareAll(input string name, input logic efull, input logic [1:0] eoc,
                              input logic [31:0] epc0, input logic [31:0] ei0,
                              input logic [31:0] epc1, input logic [31:0] ei1);
        assertions++;
        if ({Full, out_count, out_pc0, out_instr0, out_pc1, out_instr1} !==
            {efull, eoc, epc0, ei0, epc1, ei1}) begin
            failures++;
            $display("[TB] FAIL %s: got full=%b cnt=%0d pc0=%h i0=%h pc1=%h i1=%h, expected full=%b cnt=%0d pc0=%h i0=%h pc1=%h i1=%h",
                     name, Full, out_count, out_pc0, out_instr0, out_pc1, out_instr1,
                     efull, eoc, epc0, ei0, epc1, ei1);
        end
    endtask

    // Compare the DUT against the model's view of the queue.
    task automatic checkOutput(input string name);
        int occ;
        logic [1:0] eoc;
        logic [31:0] epc0, ei0, epc1, ei1;
        occ  = model_q.size();
        eoc  = 2'((occ < 2) ? occ : 2);
        epc0 = (occ > 0) ? model_q[0].pc    : 32'd0;
        ei0  = (occ > 0) ? model_q[0].instr : 32'd0;
        epc1 = (occ > 1) ? model_q[1].pc    : 32'd0;
        ei1  = (occ > 1) ? model_q[1].instr : 32'd0;
        compareAll(name, (DEPTH - occ) < 2, eoc, epc0, ei0, epc1, ei1);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] prev_pc0;
        logic [1:0]  r_inc;
        logic [1:0]  r_deq;

        // Directed vectors; expected values are the outputs just after the edge.
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{1'b0, 1'b0, 32'h00400000, 32'h11111111, 32'h22222222, 2'd2, 2'd0,
                     2'd2, 1'b0, 32'h00400000, 32'h11111111, 32'h00400004, 32'h22222222};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h00000100, 32'hAAAA0001, 32'hDEADBEEF, 2'd1, 2'd0,
                     2'd1, 1'b0, 32'h00000100, 32'hAAAA0001, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h33333333, 32'h44444444, 2'd2, 2'd0,
                     2'd2, 1'b0, 32'hFFFFFFFC, 32'h33333333, 32'h00000000, 32'h44444444};
        vecs[9]  = '{1'b0, 1'b0, 32'h00000200, 32'h55555555, 32'h0, 2'd1, 2'd0,
                     2'd2, 1'b0, 32'hFFFFFFFC, 32'h33333333, 32'h00000000, 32'h44444444};
        vecs[10] = '{1'b0, 1'b1, 32'h00000300, 32'h99999999, 32'h88888888, 2'd2, 2'd2,
                     2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h00000400, 32'h66666666, 32'h77777777, 2'd2, 2'd0,
                     2'd2, 1'b0, 32'h00000400, 32'h66666666, 32'h00000404, 32'h77777777};
        vecs[12] = '{1'b0, 1'b0, 32'h00000500, 32'hBBBBBBBB, 32'hCCCCCCCC, 2'd3, 2'd0,
                     2'd2, 1'b0, 32'h00000400, 32'h66666666, 32'h00000404, 32'h77777777};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd1,
                     2'd1, 1'b0, 32'h00000404, 32'h77777777, 32'h0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h00000600, 32'h12345678, 32'h9ABCDEF0, 2'd2, 2'd1,
                     2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

        reset = 1'b1; Flush = 1'b0; in_pc = '0; in_instr0 = '0; in_instr1 = '0;
        in_count = '0; deq_count = '0;

        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].fl, vecs[v].pc, vecs[v].i0, vecs[v].i1,
                          vecs[v].inc, vecs[v].deq);
            compareAll($sformatf("vec%0d", v), vecs[v].efull, vecs[v].eoc,
                       vecs[v].epc0, vecs[v].ei0, vecs[v].epc1, vecs[v].ei1);
            checkOutput($sformatf("vec%0d_model", v));
        end

        // Fill to DEPTH-1 with single pushes; Full must rise and refuse one more.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
        pc = 32'h00001000;
        for (int k = 0; k < DEPTH - 1; k++) begin
            applyStimulus(1'b0, 1'b0, pc, 32'hF0000000 | pc, 32'h0, 2'd1, 2'd0);
            pc = pc + 32'd4;
        end
        checkBit("fill_full", Full, 1'b1);
        checkOutput("fill_model");
        applyStimulus(1'b0, 1'b0, 32'hBAD00000, 32'hBADBAD00, 32'h0, 2'd1, 2'd0);
        checkOutput("full_refuse");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd1);
        checkBit("full_clear", Full, 1'b0);
        checkOutput("full_clear_model");
        // Drain: the refused entry must never surface.
        for (int k = 0; k < DEPTH / 2; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2);
            checkOutput($sformatf("drain%0d", k));
        end

        // Steady state across pointer wrap: push 2, pop 2 each cycle.
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
        pc = 32'h00800000;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, pc, ~pc, pc ^ 32'h5A5A5A5A, 2'd2, 2'd0);
            pc = pc + 32'd8;
        end
        prev_pc0 = out_pc0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, pc, ~pc, pc ^ 32'h5A5A5A5A, 2'd2, 2'd2);
            pc = pc + 32'd8;
            checkOutput($sformatf("steady%0d", k));
            checkBit($sformatf("steady_seq%0d", k), out_pc0 == prev_pc0 + 32'd8, 1'b1);
            prev_pc0 = out_pc0;
        end

        // Randomized run against the model, with occasional Flush and reset.
        for (int k = 0; k < 400; k++) begin
            r_inc = 2'($urandom_range(0, 3));
            r_deq = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          $urandom, $urandom, $urandom, r_inc, r_deq);
            checkOutput($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
